// File: rtl/muskoka_wb_arbiter.sv
// Two-master, one-slave Wishbone classic arbiter: round-robin grant held for a whole CYC, one-cycle grant latency.
// Define MUSKOKA_WB_ARB_TIMEOUT_EN to add a bus watchdog that errors out a hung slave after TIMEOUT_CYCLES.
module muskoka_wb_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,

  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_W-1:0]     m0_adr_i,
  input  logic [DATA_W-1:0]     m0_dat_i,
  input  logic [DATA_W/8-1:0]   m0_sel_i,
  output logic [DATA_W-1:0]     m0_dat_o,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,

  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_W-1:0]     m1_adr_i,
  input  logic [DATA_W-1:0]     m1_dat_i,
  input  logic [DATA_W/8-1:0]   m1_sel_i,
  output logic [DATA_W-1:0]     m1_dat_o,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,

  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [ADDR_W-1:0]     s_adr_o,
  output logic [DATA_W-1:0]     s_dat_o,
  output logic [DATA_W/8-1:0]   s_sel_o,
  input  logic [DATA_W-1:0]     s_dat_i,
  input  logic                  s_ack_i,
  input  logic                  s_err_i,

  output logic [1:0]            gnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   last_gnt, last_gnt_nxt;
  logic   timeout;

`ifdef MUSKOKA_WB_ARB_TIMEOUT_EN
  logic [7:0] wd_cnt;
  logic       own_stb;

  assign own_stb = (state == GNT0) ? m0_stb_i :
                   (state == GNT1) ? m1_stb_i : 1'b0;
  assign timeout = (state != IDLE) && (wd_cnt == 8'(TIMEOUT_CYCLES));

  // Counts unanswered strobe cycles of the current owner; any response or grant change restarts it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wd_cnt <= 8'd0;
    end else if ((state_nxt != state) || s_ack_i || s_err_i) begin
      wd_cnt <= 8'd0;
    end else if (own_stb && (wd_cnt != 8'hff)) begin
      wd_cnt <= wd_cnt + 8'd1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
    end else begin
      state    <= state_nxt;
      last_gnt <= last_gnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    last_gnt_nxt = last_gnt;
    case (state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_nxt = last_gnt ? GNT0 : GNT1;
        end else if (m0_cyc_i) begin
          state_nxt = GNT0;
        end else if (m1_cyc_i) begin
          state_nxt = GNT1;
        end
      end
      GNT0: begin
        // A waiting master takes over on the release edge, with no idle bubble.
        if (timeout || !m0_cyc_i) begin
          last_gnt_nxt = 1'b0;
          state_nxt    = (m1_cyc_i && !timeout) ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        if (timeout || !m1_cyc_i) begin
          last_gnt_nxt = 1'b1;
          state_nxt    = (m0_cyc_i && !timeout) ? GNT0 : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = m0_we_i;
    s_adr_o  = m0_adr_i;
    s_dat_o  = m0_dat_i;
    s_sel_o  = m0_sel_i;
    m0_dat_o = s_dat_i;
    m1_dat_o = s_dat_i;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    gnt_o    = 2'b00;
    case (state)
      GNT0: begin
        gnt_o    = 2'b01;
        s_cyc_o  = m0_cyc_i && !timeout;
        s_stb_o  = m0_stb_i && !timeout;
        m0_ack_o = s_ack_i;
        m0_err_o = s_err_i || timeout;
      end
      GNT1: begin
        gnt_o    = 2'b10;
        s_cyc_o  = m1_cyc_i && !timeout;
        s_stb_o  = m1_stb_i && !timeout;
        s_we_o   = m1_we_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        m1_ack_o = s_ack_i;
        m1_err_o = s_err_i || timeout;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_muskoka_wb_arbiter.sv
// Bench for muskoka_wb_arbiter: per-cycle vector table plus hand-written watchdog / hung-slave sequence.
module tb_muskoka_wb_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o;
  logic [3:0]  m0_sel_i;
  logic        m0_ack_o, m0_err_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [31:0] m1_adr_i, m1_dat_i, m1_dat_o;
  logic [3:0]  m1_sel_i;
  logic        m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic [3:0]  s_sel_o;
  logic        s_ack_i, s_err_i;
  logic [1:0]  gnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  muskoka_wb_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_adr_i(m0_adr_i),
    .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_adr_i(m1_adr_i),
    .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_sel_o(s_sel_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .gnt_o(gnt_o)
  );

  typedef struct {
    logic        rst, c0, s0, c1, s1, ack, err;
    logic [31:0] a1, sd;
    logic [1:0]  gnt;
    logic        scyc, sstb;
    logic [31:0] sadr;
    logic        ack0, ack1, err0, err1;
  } vec_t;

  function automatic vec_t mk(logic rst, logic c0, logic s0, logic c1, logic s1, logic ack, logic err,
                              logic [31:0] a1, logic [31:0] sd, logic [1:0] gnt, logic scyc, logic sstb,
                              logic [31:0] sadr, logic ack0, logic ack1, logic err0, logic err1);
    vec_t v;
    v.rst = rst; v.c0 = c0; v.s0 = s0; v.c1 = c1; v.s1 = s1; v.ack = ack; v.err = err;
    v.a1 = a1; v.sd = sd; v.gnt = gnt; v.scyc = scyc; v.sstb = sstb; v.sadr = sadr;
    v.ack0 = ack0; v.ack1 = ack1; v.err0 = err0; v.err1 = err1;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  vec_t vecs[35];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    // m0 single write, acked 2 cycles after cyc
    vecs[0]  = mk(0,0,0,0,0,0,0,32'h100,32'h0,        2'b00,0,0,32'h1000,0,0,0,0);
    vecs[1]  = mk(0,1,1,0,0,0,0,32'h100,32'h0,        2'b00,0,0,32'h1000,0,0,0,0);
    vecs[2]  = mk(0,1,1,0,0,0,0,32'h100,32'h0,        2'b01,1,1,32'h1000,0,0,0,0);
    vecs[3]  = mk(0,1,1,0,0,1,0,32'h100,32'h55,       2'b01,1,1,32'h1000,1,0,0,0);
    vecs[4]  = mk(0,0,0,0,0,0,0,32'h100,32'h0,        2'b01,0,0,32'h1000,0,0,0,0);
    vecs[5]  = mk(0,0,0,0,0,0,0,32'h100,32'h0,        2'b00,0,0,32'h1000,0,0,0,0);
    // spurious ack while idle
    vecs[6]  = mk(0,0,0,0,0,1,0,32'h100,32'h77,       2'b00,0,0,32'h1000,0,0,0,0);
    vecs[7]  = mk(0,0,0,0,0,0,0,32'h100,32'h0,        2'b00,0,0,32'h1000,0,0,0,0);
    // reset, then simultaneous request: m0 first, then direct handover to m1
    vecs[8]  = mk(1,0,0,0,0,0,0,32'h100,32'h0,        2'b00,0,0,32'h1000,0,0,0,0);
    vecs[9]  = mk(0,1,1,1,1,0,0,32'h100,32'h0,        2'b00,0,0,32'h1000,0,0,0,0);
    vecs[10] = mk(0,1,1,1,1,0,0,32'h100,32'h0,        2'b01,1,1,32'h1000,0,0,0,0);
    vecs[11] = mk(0,1,1,1,1,1,0,32'h100,32'h11,       2'b01,1,1,32'h1000,1,0,0,0);
    vecs[12] = mk(0,0,0,1,1,0,0,32'h100,32'h0,        2'b01,0,0,32'h1000,0,0,0,0);
    // m1 4-beat burst while m0 waits
    vecs[13] = mk(0,1,1,1,1,0,0,32'h100,32'h0,        2'b10,1,1,32'h100,0,0,0,0);
    vecs[14] = mk(0,1,1,1,1,1,0,32'h100,32'hA0000100, 2'b10,1,1,32'h100,0,1,0,0);
    vecs[15] = mk(0,1,1,1,1,1,0,32'h104,32'hB1000104, 2'b10,1,1,32'h104,0,1,0,0);
    vecs[16] = mk(0,1,1,1,1,1,0,32'h108,32'hC2000108, 2'b10,1,1,32'h108,0,1,0,0);
    vecs[17] = mk(0,1,1,1,1,1,0,32'h10C,32'hD300010C, 2'b10,1,1,32'h10C,0,1,0,0);
    vecs[18] = mk(0,1,1,0,0,0,0,32'h10C,32'h0,        2'b10,0,0,32'h10C,0,0,0,0);
    vecs[19] = mk(0,1,1,0,0,0,0,32'h100,32'h0,        2'b01,1,1,32'h1000,0,0,0,0);
    vecs[20] = mk(0,1,1,0,0,1,0,32'h100,32'h22,       2'b01,1,1,32'h1000,1,0,0,0);
    vecs[21] = mk(0,0,0,0,0,0,0,32'h100,32'h0,        2'b01,0,0,32'h1000,0,0,0,0);
    // ties alternate: last owner m0 -> m1 wins, last owner m1 -> m0 wins
    vecs[22] = mk(0,1,1,1,1,0,0,32'h100,32'h0,        2'b00,0,0,32'h1000,0,0,0,0);
    vecs[23] = mk(0,1,1,1,1,0,0,32'h100,32'h0,        2'b10,1,1,32'h100,0,0,0,0);
    vecs[24] = mk(0,0,0,0,0,0,0,32'h100,32'h0,        2'b10,0,0,32'h100,0,0,0,0);
    vecs[25] = mk(0,1,1,1,1,0,0,32'h100,32'h0,        2'b00,0,0,32'h1000,0,0,0,0);
    vecs[26] = mk(0,1,1,1,1,0,1,32'h100,32'h0,        2'b01,1,1,32'h1000,0,0,1,0);
    vecs[27] = mk(0,0,0,1,1,0,0,32'h100,32'h0,        2'b01,0,0,32'h1000,0,0,0,0);
    vecs[28] = mk(0,0,0,0,0,0,0,32'h100,32'h0,        2'b10,0,0,32'h100,0,0,0,0);
    // reset mid-transfer: the following ack is not forwarded
    vecs[29] = mk(0,1,1,0,0,0,0,32'h100,32'h0,        2'b00,0,0,32'h1000,0,0,0,0);
    vecs[30] = mk(0,1,1,0,0,0,0,32'h100,32'h0,        2'b01,1,1,32'h1000,0,0,0,0);
    vecs[31] = mk(1,1,1,0,0,0,0,32'h100,32'h0,        2'b01,1,1,32'h1000,0,0,0,0);
    vecs[32] = mk(0,1,1,0,0,1,0,32'h100,32'h33,       2'b00,0,0,32'h1000,0,0,0,0);
    vecs[33] = mk(0,0,0,0,0,0,0,32'h100,32'h0,        2'b01,0,0,32'h1000,0,0,0,0);
    vecs[34] = mk(0,0,0,0,0,0,0,32'h100,32'h0,        2'b00,0,0,32'h1000,0,0,0,0);

    rst_i = 1'b1;
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 1'b1; m0_adr_i = 32'h0000_1000;
    m0_dat_i = 32'hDEAD_BEEF; m0_sel_i = 4'hF;
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 1'b0; m1_adr_i = 32'h100;
    m1_dat_i = 32'h0; m1_sel_i = 4'h3;
    s_dat_i = 32'h0; s_ack_i = 0; s_err_i = 0;
    repeat (2) @(posedge clk_i);

    for (int i = 0; i < 35; i++) begin
      @(negedge clk_i);
      rst_i = vecs[i].rst;
      m0_cyc_i = vecs[i].c0; m0_stb_i = vecs[i].s0;
      m1_cyc_i = vecs[i].c1; m1_stb_i = vecs[i].s1; m1_adr_i = vecs[i].a1;
      s_ack_i = vecs[i].ack; s_err_i = vecs[i].err; s_dat_i = vecs[i].sd;
      #1;
      chk($sformatf("v%0d gnt", i),   32'(gnt_o),    32'(vecs[i].gnt));
      chk($sformatf("v%0d s_cyc", i), 32'(s_cyc_o),  32'(vecs[i].scyc));
      chk($sformatf("v%0d s_stb", i), 32'(s_stb_o),  32'(vecs[i].sstb));
      chk($sformatf("v%0d s_adr", i), s_adr_o,       vecs[i].sadr);
      chk($sformatf("v%0d ack0", i),  32'(m0_ack_o), 32'(vecs[i].ack0));
      chk($sformatf("v%0d ack1", i),  32'(m1_ack_o), 32'(vecs[i].ack1));
      chk($sformatf("v%0d err0", i),  32'(m0_err_o), 32'(vecs[i].err0));
      chk($sformatf("v%0d err1", i),  32'(m1_err_o), 32'(vecs[i].err1));
      if (vecs[i].gnt == 2'b10) begin
        chk($sformatf("v%0d s_we", i),  32'(s_we_o),  32'd0);
        chk($sformatf("v%0d s_sel", i), 32'(s_sel_o), 32'h3);
      end else if (vecs[i].gnt == 2'b01) begin
        chk($sformatf("v%0d s_we", i),  32'(s_we_o),  32'd1);
        chk($sformatf("v%0d s_dat", i), s_dat_o,      32'hDEAD_BEEF);
        chk($sformatf("v%0d s_sel", i), 32'(s_sel_o), 32'hF);
      end
      if (vecs[i].ack1) chk($sformatf("v%0d m1_dat", i), m1_dat_o, vecs[i].sd);
      if (vecs[i].ack0) chk($sformatf("v%0d m0_dat", i), m0_dat_o, vecs[i].sd);
    end

    // Hung slave: m0 strobes with no response while m1 waits.
    @(negedge clk_i);
    m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 0; m1_stb_i = 0; s_ack_i = 0; s_err_i = 0;
    @(negedge clk_i);
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h200;
`ifdef MUSKOKA_WB_ARB_TIMEOUT_EN
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk_i);
      #1;
      chk($sformatf("wd k%0d gnt", k),  32'(gnt_o),    32'h1);
      chk($sformatf("wd k%0d err0", k), 32'(m0_err_o), 32'h0);
      chk($sformatf("wd k%0d scyc", k), 32'(s_cyc_o),  32'h1);
    end
    @(negedge clk_i); #1;
    chk("wd fire err0", 32'(m0_err_o), 32'h1);
    chk("wd fire scyc", 32'(s_cyc_o),  32'h0);
    chk("wd fire err1", 32'(m1_err_o), 32'h0);
    @(negedge clk_i); #1;
    chk("wd after gnt",  32'(gnt_o),    32'h0);
    chk("wd after err0", 32'(m0_err_o), 32'h0);
    @(negedge clk_i); #1;
    chk("wd m1 gnt",  32'(gnt_o),   32'h2);
    chk("wd m1 sadr", s_adr_o,      32'h200);
`else
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clk_i);
      #1;
      chk($sformatf("hang k%0d gnt", k),  32'(gnt_o),    32'h1);
      chk($sformatf("hang k%0d err0", k), 32'(m0_err_o), 32'h0);
      chk($sformatf("hang k%0d scyc", k), 32'(s_cyc_o),  32'h1);
    end
`endif
    @(negedge clk_i);
    m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    repeat (3) @(posedge clk_i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
